// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply sequencer. The ACCUM state exists
// only when HILO_ACCUM_EN is defined.
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_MULU = 4'b1011;
    localparam logic [3:0] ALU_AND  = 4'b0000;

`ifdef HILO_ACCUM_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_ACCUM
    } state_t;
`else
    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;
`endif

    // Only MULTU uses the unsigned multiplier; MADD/MSUB are signed like MULT.
    function automatic logic [3:0] alu_ctrl_for(input logic [2:0] op);
        return (op == OP_MULTU) ? ALU_MULU : ALU_MUL;
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef HILO_ACCUM_EN
        r = r || (op == OP_MADD) || (op == OP_MSUB);
`endif
        return r;
    endfunction

endpackage

// File: rtl/hilo_acc64.sv
// Combinational 64-bit add/subtract of {Hi,Lo} and the captured product.
// Present only when HILO_ACCUM_EN is defined.
`ifdef HILO_ACCUM_EN
module hilo_acc64 (
    input  logic [63:0] hilo,
    input  logic [63:0] p,
    input  logic        sub,
    output logic [63:0] result
);

    always_comb begin
        result = sub ? (hilo - p) : (hilo + p);
    end

endmodule
`endif

// File: rtl/hilo_mul_controller.sv
// HI/LO owner that sequences the shared ALU through multi-cycle multiplies.
// Define HILO_ACCUM_EN to compile in MADD/MSUB and the ACCUM state.
module hilo_mul_controller
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    input  logic [31:0] AluResult,
    input  logic [31:0] AluHi,
    output logic [3:0]  ALUControl,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam logic [3:0] LAT_M1 = 4'(MUL_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        done_reg, done_next;
    logic        busy_reg, busy_next;
    logic [3:0]  alu_ctrl_reg, alu_ctrl_next;
    logic [31:0] alu_a_reg, alu_a_next;
    logic [31:0] alu_b_reg, alu_b_next;
    logic [63:0] product;

    assign product = {AluHi, AluResult};

`ifdef HILO_ACCUM_EN
    logic [63:0] p_reg, p_next;
    logic [63:0] acc_sum;

    hilo_acc64 u_acc (
        .hilo   ({hi_reg, lo_reg}),
        .p      (p_reg),
        .sub    (op_reg == OP_MSUB),
        .result (acc_sum)
    );
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
`ifdef HILO_ACCUM_EN
        p_next     = p_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (Start && !Cancel) begin
                    if (Op == OP_MTHI) begin
                        hi_next   = A;
                        done_next = 1'b1;
                    end else if (Op == OP_MTLO) begin
                        lo_next   = A;
                        done_next = 1'b1;
                    end else if (is_mul_op(Op)) begin
                        op_next    = Op;
                        a_next     = A;
                        b_next     = B;
                        cnt_next   = LAT_M1;
                        state_next = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (Cancel) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == 4'd0) begin
`ifdef HILO_ACCUM_EN
                    if (op_reg == OP_MADD || op_reg == OP_MSUB) begin
                        p_next     = product;
                        state_next = ST_ACCUM;
                    end else
`endif
                    begin
                        {hi_next, lo_next} = product;
                        done_next          = 1'b1;
                        state_next         = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
`ifdef HILO_ACCUM_EN
            ST_ACCUM: begin
                if (!Cancel) begin
                    {hi_next, lo_next} = acc_sum;
                    done_next          = 1'b1;
                end
                state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they change on the edge.
    always_comb begin
        busy_next     = (state_next != ST_IDLE);
        alu_ctrl_next = ALU_AND;
        alu_a_next    = 32'd0;
        alu_b_next    = 32'd0;
        if (state_next == ST_MUL) begin
            alu_ctrl_next = alu_ctrl_for(op_next);
            alu_a_next    = a_next;
            alu_b_next    = b_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            op_reg       <= 3'd0;
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            alu_ctrl_reg <= ALU_AND;
            alu_a_reg    <= 32'd0;
            alu_b_reg    <= 32'd0;
`ifdef HILO_ACCUM_EN
            p_reg        <= 64'd0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            done_reg     <= done_next;
            busy_reg     <= busy_next;
            alu_ctrl_reg <= alu_ctrl_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
`ifdef HILO_ACCUM_EN
            p_reg        <= p_next;
`endif
        end
    end

    assign ALUControl = alu_ctrl_reg;
    assign AluA       = alu_a_reg;
    assign AluB       = alu_b_reg;
    assign Busy       = busy_reg;
    assign Done       = done_reg;
    assign Hi         = hi_reg;
    assign Lo         = lo_reg;

endmodule

// File: tb/tb_hilo_mul_controller.sv
// Directed bench for hilo_mul_controller with a behavioural multiplier ALU.
// Expectations for MADD/MSUB follow whether HILO_ACCUM_EN is defined.
module tb_hilo_mul_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Cancel = 1'b0;
    logic [31:0] AluResult;
    logic [31:0] AluHi;
    logic [3:0]  ALUControl;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [63:0] prod;

    int checks = 0;
    int errors = 0;

    hilo_mul_controller #(.MUL_LATENCY(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Op         (Op),
        .A          (A),
        .B          (B),
        .Cancel     (Cancel),
        .AluResult  (AluResult),
        .AluHi      (AluHi),
        .ALUControl (ALUControl),
        .AluA       (AluA),
        .AluB       (AluB),
        .Busy       (Busy),
        .Done       (Done),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    always #5 Clk = ~Clk;

    // Behavioural shared ALU: combinational product of the driven operands.
    always_comb begin
        prod = 64'd0;
        if (ALUControl == 4'b1010)
            prod = $signed({{32{AluA[31]}}, AluA}) * $signed({{32{AluB[31]}}, AluB});
        else if (ALUControl == 4'b1011)
            prod = {32'd0, AluA} * {32'd0, AluB};
    end
    assign AluHi     = prod[63:32];
    assign AluResult = prod[31:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        step();
        Start = 1'b0;
    endtask

    // Called right after issue(); counts steps to Done and cycles with Busy high.
    task automatic wait_done(input string tag, input int exp_n);
        int n = 0;
        int busy_cnt = 0;
        if (Busy === 1'b1) busy_cnt++;
        while (Done !== 1'b1 && n < 20) begin
            step();
            n++;
            if (Busy === 1'b1) busy_cnt++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_n));
    endtask

    task automatic expect_idle(input string tag);
        int bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (Busy !== 1'b0 || Done !== 1'b0) bad++;
            step();
        end
        chk({tag, "_idle"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #3;
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_aluctl", 64'(ALUControl), 64'd0);
        chk("rst_alua", 64'(AluA), 64'd0);
        chk("rst_alub", 64'(AluB), 64'd0);
        #3 Reset = 1'b0;
        step();

        // MULTU all-ones
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy", 64'(Busy), 64'd1);
        chk("multu_aluctl", 64'(ALUControl), 64'hB);
        chk("multu_alua", 64'(AluA), 64'hFFFF_FFFF);
        chk("multu_alub", 64'(AluB), 64'hFFFF_FFFF);
        wait_done("multu", 4);
        chk("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(Lo), 64'h0000_0001);
        chk("multu_busy_end", 64'(Busy), 64'd0);
        step();
        chk("multu_done_pulse", 64'(Done), 64'd0);

        // Signed MULT -2 * 3
        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        chk("mult_aluctl", 64'(ALUControl), 64'hA);
        wait_done("mult_neg", 4);
        chk("mult_neg_hi", 64'(Hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo", 64'(Lo), 64'hFFFF_FFFA);

        // MULT 2^16 * 2^16 then MADD 2*3 issued back-to-back in the Done cycle
        issue(3'b000, 32'h0001_0000, 32'h0001_0000);
        wait_done("mult_2p32", 4);
        chk("mult_2p32_hi", 64'(Hi), 64'd1);
        chk("mult_2p32_lo", 64'(Lo), 64'd0);
        issue(3'b010, 32'd2, 32'd3);
`ifdef HILO_ACCUM_EN
        wait_done("madd", 5);
        chk("madd_hi", 64'(Hi), 64'd1);
        chk("madd_lo", 64'(Lo), 64'd6);
`else
        chk("madd_ill_busy", 64'(Busy), 64'd0);
        expect_idle("madd_ill");
        chk("madd_ill_hi", 64'(Hi), 64'd1);
        chk("madd_ill_lo", 64'(Lo), 64'd0);
`endif
        step();

        // Clear HI/LO with back-to-back MTHI/MTLO, then MSUB 1*1
        issue(3'b100, 32'd0, 32'd0);
        chk("mthi0_hi", 64'(Hi), 64'd0);
        chk("mthi0_done", 64'(Done), 64'd1);
        issue(3'b101, 32'd0, 32'd0);
        chk("mtlo0_lo", 64'(Lo), 64'd0);
        chk("mtlo0_done", 64'(Done), 64'd1);
        step();
        issue(3'b011, 32'd1, 32'd1);
`ifdef HILO_ACCUM_EN
        wait_done("msub", 5);
        chk("msub_hi", 64'(Hi), 64'hFFFF_FFFF);
        chk("msub_lo", 64'(Lo), 64'hFFFF_FFFF);
`else
        chk("msub_ill_busy", 64'(Busy), 64'd0);
        expect_idle("msub_ill");
        chk("msub_ill_hi", 64'(Hi), 64'd0);
        chk("msub_ill_lo", 64'(Lo), 64'd0);
`endif
        step();

        // MTHI / MTLO
        issue(3'b100, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(Hi), 64'h1234_5678);
        chk("mthi_done", 64'(Done), 64'd1);
        chk("mthi_busy", 64'(Busy), 64'd0);
        step();
        chk("mthi_done_pulse", 64'(Done), 64'd0);
        chk("mthi_busy2", 64'(Busy), 64'd0);
        issue(3'b101, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo_lo", 64'(Lo), 64'h9ABC_DEF0);
        chk("mtlo_hi_keep", 64'(Hi), 64'h1234_5678);
        chk("mtlo_done", 64'(Done), 64'd1);
        step();

        // Illegal op and Start suppressed by Cancel in IDLE
        issue(3'b110, 32'd5, 32'd5);
        expect_idle("illegal");
        Cancel = 1'b1;
        issue(3'b100, 32'hDEAD_BEEF, 32'd0);
        Cancel = 1'b0;
        chk("cancel_idle_hi", 64'(Hi), 64'h1234_5678);
        chk("cancel_idle_done", 64'(Done), 64'd0);

        // MULT, ignored MULTU Start in busy cycle 2, Cancel in cycle 3
        issue(3'b000, 32'd7, 32'd9);
        step();
        issue(3'b001, 32'd2, 32'd2);
        chk("ignored_aluctl", 64'(ALUControl), 64'hA);
        chk("ignored_alua", 64'(AluA), 64'd7);
        Cancel = 1'b1;
        step();
        Cancel = 1'b0;
        chk("cancel_busy", 64'(Busy), 64'd0);
        chk("cancel_done", 64'(Done), 64'd0);
        expect_idle("cancel");
        chk("cancel_hi", 64'(Hi), 64'h1234_5678);
        chk("cancel_lo", 64'(Lo), 64'h9ABC_DEF0);

        // Asynchronous reset in the middle of MUL
        issue(3'b000, 32'd4, 32'd4);
        #2 Reset = 1'b1;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_done", 64'(Done), 64'd0);
        chk("arst_hi", 64'(Hi), 64'd0);
        chk("arst_lo", 64'(Lo), 64'd0);
        chk("arst_aluctl", 64'(ALUControl), 64'd0);
        #2 Reset = 1'b0;
        step();
        issue(3'b000, 32'd3, 32'd5);
        wait_done("post_rst", 4);
        chk("post_rst_lo", 64'(Lo), 64'd15);
        chk("post_rst_hi", 64'(Hi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
